// File: rtl/seq1011_frame_tx_if.sv
// rtl/seq1011_frame_tx_if.sv - word handshake and serial line bundle for the 1011 frame transmitter
interface seq1011_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              dout;
  logic              dout_valid;
  logic              frame_done;

  // word source / line consumer side
  modport master (
    output in_valid, in_data,
    input  in_ready, dout, dout_valid, frame_done
  );

  // transmitter side
  modport slave (
    input  in_valid, in_data,
    output in_ready, dout, dout_valid, frame_done
  );
endinterface

// File: rtl/seq1011_frame_tx.sv
// rtl/seq1011_frame_tx.sv - serial framer: sync 1011, payload MSB first, optional even parity, idle gap
module seq1011_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP_LEN   = 2
) (
  input  logic               clk,
  input  logic               rst,
  seq1011_frame_tx_if.slave  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SYNC = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] PAR  = 3'd3;
  localparam logic [2:0] GAP  = 3'd4;

  // one counter serves every timed state, so it must span the longest of them
  localparam int CMAX = (DATA_W > GAP_LEN) ? ((DATA_W > 4) ? DATA_W : 4)
                                           : ((GAP_LEN > 4) ? GAP_LEN : 4);
  localparam int CW   = $clog2(CMAX);

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sr;
  logic              par;

  // state, counter and shift register advance; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      par   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sr    <= bus.in_data;
            par   <= ^bus.in_data;
            cnt   <= '0;
            state <= SYNC;
          end
        end
        SYNC: begin
          if (int'(cnt) >= 3) begin
            cnt   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          sr <= sr << 1;
          if (int'(cnt) >= DATA_W - 1) begin
            cnt   <= '0;
            state <= (PARITY_EN != 0) ? PAR : ((GAP_LEN > 0) ? GAP : IDLE);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PAR: begin
          cnt   <= '0;
          state <= (GAP_LEN > 0) ? GAP : IDLE;
        end
        GAP: begin
          if (int'(cnt) >= GAP_LEN - 1) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore output decode from registered state only; sync pattern 1,0,1,1 is "not count 1"
  always_comb begin
    bus.in_ready   = 1'b0;
    bus.dout       = 1'b0;
    bus.dout_valid = 1'b0;
    bus.frame_done = 1'b0;
    case (state)
      IDLE: bus.in_ready = 1'b1;
      SYNC: begin
        bus.dout       = (int'(cnt) != 1);
        bus.dout_valid = 1'b1;
      end
      DATA: begin
        bus.dout       = sr[DATA_W-1];
        bus.dout_valid = 1'b1;
        bus.frame_done = (PARITY_EN == 0) && (int'(cnt) == DATA_W - 1);
      end
      PAR: begin
        bus.dout       = par;
        bus.dout_valid = 1'b1;
        bus.frame_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq1011_frame_tx.sv
// tb/tb_seq1011_frame_tx.sv - randomized scoreboard bench for the 1011 frame transmitter
module tb_seq1011_frame_tx;

  typedef struct packed {
    logic rdy;
    logic d;
    logic dv;
    logic fd;
  } exp_t;

  localparam exp_t IDLE_E = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0 = IDLE_E;
  exp_t e1 = IDLE_E;
  int   acc0[$];
  int   acc1[$];
  logic [3:0] win = 4'b0;
  int   det_cnt = 0;

  seq1011_frame_tx_if #(.DATA_W(8)) bus0 ();
  seq1011_frame_tx_if #(.DATA_W(4)) bus1 ();

  seq1011_frame_tx dut0 (.clk(clk), .rst(rst), .bus(bus0));
  seq1011_frame_tx #(.DATA_W(4), .PARITY_EN(0), .GAP_LEN(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void push_exp(input int which, input exp_t x);
    if (which == 0) q0.push_back(x);
    else q1.push_back(x);
  endfunction

  // expected line activity for one frame: sync, payload MSB first, parity, then the gap
  function automatic void push_frame(input int which, input int dw, input int pe, input int gl,
                                     input logic [31:0] d);
    bit b[$];
    bit p = 1'b0;
    b.push_back(1'b1);
    b.push_back(1'b0);
    b.push_back(1'b1);
    b.push_back(1'b1);
    for (int i = dw - 1; i >= 0; i--) begin
      b.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe != 0) b.push_back(p);
    for (int k = 0; k < b.size(); k++)
      push_exp(which, exp_t'({1'b0, b[k], 1'b1, (k == b.size() - 1)}));
    for (int g = 0; g < gl; g++)
      push_exp(which, exp_t'(4'b0000));
  endfunction

  // per-cycle scoreboard, reference model update and downstream sync detector
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check("d0_ready", bus0.in_ready,   e0.rdy);
      check("d0_dout",  bus0.dout,       e0.d);
      check("d0_dv",    bus0.dout_valid, e0.dv);
      check("d0_done",  bus0.frame_done, e0.fd);
      check("d1_ready", bus1.in_ready,   e1.rdy);
      check("d1_dout",  bus1.dout,       e1.d);
      check("d1_dv",    bus1.dout_valid, e1.dv);
      check("d1_done",  bus1.frame_done, e1.fd);
      win = {win[2:0], bus0.dout};
      if (win == 4'b1011) begin
        det_cnt++;
        win = 4'b0;
      end
      if (!rst && bus0.in_ready && bus0.in_valid) acc0.push_back(cyc);
      if (!rst && bus1.in_ready && bus1.in_valid) acc1.push_back(cyc);
      if (rst) begin
        q0.delete();
        q1.delete();
        e0 = IDLE_E;
        e1 = IDLE_E;
      end else begin
        if (e0.rdy && bus0.in_valid) push_frame(0, 8, 1, 2, {24'b0, bus0.in_data});
        if (e1.rdy && bus1.in_valid) push_frame(1, 4, 0, 0, {28'b0, bus1.in_data});
        e0 = (q0.size() > 0) ? q0.pop_front() : IDLE_E;
        e1 = (q1.size() > 0) ? q1.pop_front() : IDLE_E;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc0();
    bit rdy = 1'b0;
    for (int n = 0; n < 100; n++) begin
      rdy = bus0.in_ready;
      tick();
      if (rdy) break;
    end
    check("acc0_timeout", rdy, 1'b1);
  endtask

  task automatic wait_acc1();
    bit rdy = 1'b0;
    for (int n = 0; n < 100; n++) begin
      rdy = bus1.in_ready;
      tick();
      if (rdy) break;
    end
    check("acc1_timeout", rdy, 1'b1);
  endtask

  task automatic send0(input logic [7:0] d);
    bus0.in_valid = 1'b1;
    bus0.in_data  = d;
    wait_acc0();
    bus0.in_valid = 1'b0;
    bus0.in_data  = 8'($urandom);
  endtask

  task automatic send1(input logic [3:0] d);
    bus1.in_valid = 1'b1;
    bus1.in_data  = d;
    wait_acc1();
    bus1.in_valid = 1'b0;
    bus1.in_data  = 4'($urandom);
  endtask

  initial begin
    int base;
    bus0.in_valid = 1'b0;
    bus0.in_data  = 8'h00;
    bus1.in_valid = 1'b0;
    bus1.in_data  = 4'h0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();

    send0(8'hA5);
    repeat (20) tick();
    send0(8'h01);
    repeat (20) tick();

    // held valid: second word must wait a full frame period and in_data churn is ignored
    acc0.delete();
    bus0.in_valid = 1'b1;
    bus0.in_data  = 8'hFF;
    wait_acc0();
    bus0.in_data  = 8'h00;
    wait_acc0();
    bus0.in_data  = 8'h5A;
    bus0.in_valid = 1'b0;
    repeat (20) tick();
    check("period_d0", (acc0.size() >= 2) ? acc0[1] - acc0[0] : 0, 16);

    acc1.delete();
    bus1.in_valid = 1'b1;
    bus1.in_data  = 4'b0110;
    wait_acc1();
    wait_acc1();
    bus1.in_valid = 1'b0;
    repeat (12) tick();
    check("period_d1", (acc1.size() >= 2) ? acc1[1] - acc1[0] : 0, 9);

    // reset lands on the edge that ends the 3rd payload bit of C3
    send0(8'hC3);
    repeat (6) tick();
    check("c3_midframe_dv", bus0.dout_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", bus0.in_ready, 1'b1);
    check("abort_dout", bus0.dout, 1'b0);
    check("abort_dv", bus0.dout_valid, 1'b0);
    repeat (3) tick();
    base = det_cnt;
    send0(8'h3C);
    repeat (20) tick();
    check("sync_count", det_cnt - base, 1);

    for (int i = 0; i < 40; i++) begin
      fork
        send0(8'($urandom));
        send1(4'($urandom));
      join
      repeat ($urandom_range(0, 20)) tick();
    end
    repeat (25) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq1011_frame_tx.md
# seq1011_frame_tx

Serial frame transmitter that generates the bitstream consumed by the team's non-overlapping "1011" Moore sequence detectors. It accepts a parallel word over a valid/ready handshake and shifts out the 4-bit sync word 1011, then the payload MSB first, then an optional even-parity bit. It then holds the line low for a programmable inter-frame gap. It sits upstream of the detector-based receivers and drives stimulus and link traffic for them.

## Interface
- DATA_W, 8: payload width in bits; legal range 1..32.
- PARITY_EN, 1: 1 = append even-parity bit after payload; 0 = no parity bit.
- GAP_LEN, 2: number of forced-idle cycles after each frame; legal range 0..15.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  source has a word on in_data.
- in_data  input  DATA_W  payload word.
- in_ready  output  1  block can accept a word; high only in IDLE.
- dout  output  1  serial bit; 0 whenever not transmitting.
- dout_valid  output  1  high on every cycle that carries a frame bit (sync, payload, parity).
- frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.

## Operation
- Moore FSM states: IDLE, SYNC, DATA, PAR, GAP. All outputs are decoded from registered state, bit counter and shift register only. No input-to-output combinational path.
- IDLE:
  - in_ready=1, dout=0, dout_valid=0.
  - On in_valid=1, capture in_data into the shift register. Compute parity = XOR of in_data. Clear the counter and go to SYNC.
- SYNC: 4 cycles. dout = 1,0,1,1 in order, dout_valid=1. Then go to DATA.
- DATA:
  - DATA_W cycles; dout = shift-register MSB, shifted left each cycle, dout_valid=1.
  - Then go to PAR if PARITY_EN=1.
  - Otherwise go to GAP if GAP_LEN>0, else IDLE.
- PAR: 1 cycle. dout = parity bit, so the total ones count of payload plus parity is even. dout_valid=1. Then go to GAP if GAP_LEN>0, else IDLE.
- GAP: GAP_LEN cycles. dout=0, dout_valid=0, in_ready=0. Then go to IDLE.
- frame_done=1 only on the final dout_valid cycle: last DATA cycle when PARITY_EN=0, PAR cycle when PARITY_EN=1.
- in_valid outside IDLE is ignored. No data is captured and no error is flagged. The source must hold in_valid/in_data until it sees in_ready=1 at a clock edge.
- Illegal or unused state encodings go to IDLE on the next edge.
- The counter is sized for max(4, DATA_W, GAP_LEN). It must not wrap within any state.

## Timing
- Reset values (the cycle after the rst edge, from then until the first accept):
  - state IDLE, counter 0, shift register 0.
  - in_ready=1, dout=0, dout_valid=0, frame_done=0.
- rst asserted at any point (mid-SYNC, DATA, PAR or GAP) aborts the frame at that edge. The partial frame is not resumed and the captured word is discarded.
- rst has priority over an in_valid handshake on the same edge; no word is captured.
- Accept edge E0 is the edge where state=IDLE and in_valid=1.
- First sync bit appears in the cycle immediately after E0 (latency 1 cycle).
- Frame bits occupy 4 + DATA_W + PARITY_EN consecutive cycles with dout_valid continuously high.
- Frame period is 4 + DATA_W + PARITY_EN + GAP_LEN + 1 cycles, including the IDLE accept cycle. Defaults give 16 cycles.
- With GAP_LEN=0 and in_valid held high, one dout_valid=0 cycle (IDLE) separates frames.
- The payload cannot collide with a frame start on the line: at least one 0 (IDLE) always precedes each sync word.

## Test plan
- Reset, then idle with in_valid=0 for 10 cycles:
  - in_ready=1, dout=0, dout_valid=0, frame_done=0 throughout.
- Defaults, in_data=8'hA5 accepted at E0:
  - cycles E0+1..E0+13 give dout = 1011 10100101 0; dout_valid=1; frame_done only at E0+13.
  - Then 2 gap cycles with in_ready=0.
  - in_ready=1 again at E0+16.
- Defaults, in_data=8'h01 → payload 00000001, parity bit 1.
- in_valid held high with in_data=8'hFF then 8'h00, defaults:
  - second accept exactly 16 cycles after the first.
  - parity bits are 0 and 0.
  - in_data changes during a frame do not alter the transmitted bits.
- PARITY_EN=0, GAP_LEN=0, DATA_W=4, in_data=4'b0110:
  - dout = 1011 0110; frame_done on the 8th bit.
  - next accept 9 cycles after the first.
- Assert rst for 1 cycle during the 3rd payload bit of 8'hC3:
  - the next cycle shows dout=0, dout_valid=0, in_ready=1.
  - A subsequent 8'h3C frame is transmitted complete and correct.
  - A downstream "1011" non-overlapping detector fed dout counts exactly one sync per complete frame.
